// File: rtl/double_op_driver.sv
// Initiator-side sequencer for the 64-bit stb/ack operand protocol: feeds
// LFSR-generated operand pairs to a double unit and reports each (a, b, z).
module double_op_driver #(
  parameter int unsigned NUM_OPS = 100,
  parameter logic [63:0] SEED_A  = 64'h0000_0000_0000_0001,
  parameter logic [63:0] SEED_B  = 64'h0000_0000_0000_0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [63:0] output_a,
  output logic        output_a_stb,
  input  logic        output_a_ack,
  output logic [63:0] output_b,
  output logic        output_b_stb,
  input  logic        output_b_ack,
  input  logic [63:0] input_z,
  input  logic        input_z_stb,
  output logic        input_z_ack,
  output logic [63:0] result_a,
  output logic [63:0] result_b,
  output logic [63:0] result_z,
  output logic        result_valid,
  output logic [31:0] count,
  output logic        busy,
  output logic        done
);

  localparam int unsigned W_DATA = 64;
  localparam int unsigned W_CNT  = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SEND   = 3'd1;
  localparam logic [2:0] S_WAIT_Z = 3'd2;
  localparam logic [2:0] S_REPORT = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [W_DATA-1:0] SEED_A_EFF = (SEED_A == '0) ? W_DATA'(1) : SEED_A;
  localparam logic [W_DATA-1:0] SEED_B_EFF = (SEED_B == '0) ? W_DATA'(1) : SEED_B;
  localparam logic [W_CNT-1:0]  NUM_OPS_C  = W_CNT'(NUM_OPS);

  function automatic logic [W_DATA-1:0] lfsr_step(input logic [W_DATA-1:0] cur);
    return {cur[W_DATA-2:0], 1'b0} ^ (cur[W_DATA-1] ? 64'h1B : 64'h0);
  endfunction

  logic [2:0]        r_state,     w_state;
  logic [W_DATA-1:0] r_lfsr_a,    w_lfsr_a;
  logic [W_DATA-1:0] r_lfsr_b,    w_lfsr_b;
  logic [W_DATA-1:0] r_out_a,     w_out_a;
  logic [W_DATA-1:0] r_out_b,     w_out_b;
  logic              r_a_stb,     w_a_stb;
  logic              r_b_stb,     w_b_stb;
  logic              r_z_ack,     w_z_ack;
  logic [W_DATA-1:0] r_res_a,     w_res_a;
  logic [W_DATA-1:0] r_res_b,     w_res_b;
  logic [W_DATA-1:0] r_res_z,     w_res_z;
  logic              r_res_valid, w_res_valid;
  logic [W_CNT-1:0]  r_count,     w_count;
  logic              r_busy,      w_busy;
  logic              r_done,      w_done;
  logic              w_a_xfer,    w_b_xfer;

  assign w_a_xfer = r_a_stb & output_a_ack;
  assign w_b_xfer = r_b_stb & output_b_ack;

  // Next-state and next-output logic
  always_comb begin
    w_state     = r_state;
    w_lfsr_a    = r_lfsr_a;
    w_lfsr_b    = r_lfsr_b;
    w_out_a     = r_out_a;
    w_out_b     = r_out_b;
    w_a_stb     = r_a_stb;
    w_b_stb     = r_b_stb;
    w_z_ack     = r_z_ack;
    w_res_a     = r_res_a;
    w_res_b     = r_res_b;
    w_res_z     = r_res_z;
    w_res_valid = 1'b0;
    w_count     = r_count;

    if (w_a_xfer) w_lfsr_a = lfsr_step(r_lfsr_a);
    if (w_b_xfer) w_lfsr_b = lfsr_step(r_lfsr_b);

    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state = S_SEND;
          w_out_a = r_lfsr_a;
          w_out_b = r_lfsr_b;
          w_a_stb = 1'b1;
          w_b_stb = 1'b1;
          w_count = '0;
        end
      end
      S_SEND: begin
        w_a_stb = r_a_stb & ~output_a_ack;
        w_b_stb = r_b_stb & ~output_b_ack;
        if (!w_a_stb && !w_b_stb) begin
          w_state = S_WAIT_Z;
          w_z_ack = 1'b1;
        end
      end
      S_WAIT_Z: begin
        if (input_z_stb) begin
          w_state     = S_REPORT;
          w_res_z     = input_z;
          w_res_a     = r_out_a;
          w_res_b     = r_out_b;
          w_z_ack     = 1'b0;
          w_res_valid = 1'b1;
          w_count     = r_count + W_CNT'(1);
        end
      end
      S_REPORT: begin
        if (r_count == NUM_OPS_C) begin
          w_state = S_DONE;
        end else begin
          w_state = S_SEND;
          w_out_a = r_lfsr_a;
          w_out_b = r_lfsr_b;
          w_a_stb = 1'b1;
          w_b_stb = 1'b1;
        end
      end
      default: w_state = S_IDLE;
    endcase

    w_busy = (w_state == S_SEND) || (w_state == S_WAIT_Z) || (w_state == S_REPORT);
    w_done = (w_state == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_lfsr_a    <= SEED_A_EFF;
      r_lfsr_b    <= SEED_B_EFF;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_a_stb     <= 1'b0;
      r_b_stb     <= 1'b0;
      r_z_ack     <= 1'b0;
      r_res_a     <= '0;
      r_res_b     <= '0;
      r_res_z     <= '0;
      r_res_valid <= 1'b0;
      r_count     <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_lfsr_a    <= w_lfsr_a;
      r_lfsr_b    <= w_lfsr_b;
      r_out_a     <= w_out_a;
      r_out_b     <= w_out_b;
      r_a_stb     <= w_a_stb;
      r_b_stb     <= w_b_stb;
      r_z_ack     <= w_z_ack;
      r_res_a     <= w_res_a;
      r_res_b     <= w_res_b;
      r_res_z     <= w_res_z;
      r_res_valid <= w_res_valid;
      r_count     <= w_count;
      r_busy      <= w_busy;
      r_done      <= w_done;
    end
  end

  assign output_a     = r_out_a;
  assign output_a_stb = r_a_stb;
  assign output_b     = r_out_b;
  assign output_b_stb = r_b_stb;
  assign input_z_ack  = r_z_ack;
  assign result_a     = r_res_a;
  assign result_b     = r_res_b;
  assign result_z     = r_res_z;
  assign result_valid = r_res_valid;
  assign count        = r_count;
  assign busy         = r_busy;
  assign done         = r_done;

endmodule

// File: doc/double_op_driver.md
# double_op_driver

Initiator-side sequencer for the 64-bit stb/ack operand protocol used by the double-precision arithmetic units (divider, multiplier, adder). It generates deterministic pseudo-random operand pairs from two LFSRs, offers them to the unit's `input_a`/`input_b` ports, and accepts each `output_z`. Each (a, b, z) triple is presented on a result port for a checker or trace logger, giving an in-hardware soak test of any double unit over `NUM_OPS` operations.

## Interface
- `NUM_OPS`, default 100: operations per run; 1..2^32-1.
- `SEED_A`, default 64'h0000_0000_0000_0001: LFSR A reset value; a value of 0 is replaced by 1.
- `SEED_B`, default 64'h0000_0000_0000_0002: LFSR B reset value; a value of 0 is replaced by 1.

- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous reset, active-low.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `output_a` out 64: operand A toward the unit's `input_a`.
- `output_a_stb` out 1: operand A valid.
- `output_a_ack` in 1: unit accepted A.
- `output_b` out 64: operand B toward the unit's `input_b`.
- `output_b_stb` out 1: operand B valid.
- `output_b_ack` in 1: unit accepted B.
- `input_z` in 64: result from the unit's `output_z`.
- `input_z_stb` in 1: result valid.
- `input_z_ack` out 1: result accepted.
- `result_a` out 64: operand A of the last completed operation.
- `result_b` out 64: operand B of the last completed operation.
- `result_z` out 64: result of the last completed operation.
- `result_valid` out 1: one-cycle pulse per completed operation.
- `count` out 32: completed operations in the current run.
- `busy` out 1: high in SEND, WAIT_Z and REPORT.
- `done` out 1: high in DONE.

## Operation
- **LFSR step.** Each LFSR is a 64-bit Galois LFSR, polynomial x^64+x^4+x^3+x+1. Step: `next = {cur[62:0],1'b0} ^ (cur[63] ? 64'h1B : 64'h0)`.
  - LFSR A advances once on the edge where A transfers.
  - LFSR B advances once on the edge where B transfers.
- **States.** IDLE, SEND, WAIT_Z, REPORT, DONE.
- **IDLE.**
  - `start`=1 → SEND.
  - On that edge: `output_a` ← LFSR A, `output_b` ← LFSR B, both stb ← 1, `count` ← 0.
- **SEND.**
  - A transfer: edge where `output_a_stb`=1 and `output_a_ack`=1. Clears `output_a_stb`.
  - B transfer: edge where `output_b_stb`=1 and `output_b_ack`=1. Clears `output_b_stb`.
  - A and B are independent; either order, same edge allowed.
  - `output_a` and `output_b` are stable while their stb is high.
  - Once both have transferred: → WAIT_Z, `input_z_ack` ← 1.
- **WAIT_Z.**
  - On an edge with `input_z_stb`=1: `result_z` ← `input_z`, `result_a` ← `output_a`, `result_b` ← `output_b`, `input_z_ack` ← 0, `result_valid` ← 1, `count` ← `count`+1 → REPORT.
- **REPORT.** Lasts one cycle; `result_valid` ← 0.
  - If `count` == `NUM_OPS` → DONE.
  - Else → SEND, loading new operands from the LFSRs and setting both stb.
- **DONE.** `start`=1 behaves as in IDLE. LFSRs are not reseeded, so the sequence continues.
- **Stray inputs.** `start` is ignored while `busy`. Acks and `input_z_stb` arriving outside their state are ignored.
- **Reset.** `rst`=0 at any edge, including mid-transfer, forces:
  - state IDLE;
  - all stb, `input_z_ack`, `result_valid`, `busy`, `done` ← 0;
  - `count` and all 64-bit outputs ← 0;
  - LFSRs ← seeds.

## Timing
- First stb goes high in the cycle after the edge that samples `start`.
- stb falls in the cycle after its transfer edge.
- `input_z_ack` rises in the cycle after the last operand transfer.
- `result_valid` is high in the cycle after the z transfer.
- Next operand stbs rise in the cycle after REPORT.
- With zero-wait responders, one operation takes 3 cycles: SEND, WAIT_Z, REPORT.
- `done` rises the cycle after the final REPORT and holds until `start` or reset.
- No combinational path from any input to any output.

## Test plan
- **Reset.** Hold `rst`=0 for 3 cycles with random inputs → every output 0, `busy`=0, `done`=0.
- **Zero-wait responder, default seeds, `NUM_OPS`=3.**
  - Operand pairs, in order: (1, 2), (2, 4), (4, 8).
  - `result_valid` pulses 3 cycles apart.
  - `count` reads 1, 2, 3; `done` rises after the third pulse.
- **Skewed acks.** `output_a_ack` at cycle 1, `output_b_ack` at cycle 5 →
  - `output_a_stb` low from cycle 2;
  - `output_b_stb` high through cycle 5;
  - `input_z_ack` rises at cycle 6.
- **Z back-pressure.** Delay `input_z_stb` 20 cycles → `input_z_ack` held high throughout, operands stable, single `result_valid` pulse carrying the delayed `input_z`.
- **LFSR wrap.** `SEED_A`=64'h8000_0000_0000_0000 → operand A sequence is 64'h8000_0000_0000_0000, then 64'h1B.
- **Reset mid-run.** Assert reset during WAIT_Z of op 2, then `start` → LFSRs reseeded, first pair (1, 2) again, `count` restarts at 0. Also check that `start` while `busy` is ignored.
